// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART types and constants
// Contents: tx_state_t serializer states, frame geometry, default baud divisor.
package spart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int FRAME_BITS = 10;   // start + 8 data + stop
   localparam int DATA_BITS  = 8;

   // Shared with the receiver and baud-rate logic.
   localparam logic [15:0] DEFAULT_BAUD_DIV = 16'd434;

endpackage

// File: rtl/spart_tx_buffer_if.sv
// rtl/spart_tx_buffer_if.sv - processor send port into the SPART transmit buffer
// Signals: send/send_data (push request + byte), full (back-pressure),
//          count (FIFO occupancy). master = processor side, slave = buffer side.
interface spart_tx_buffer_if #(
   parameter int DEPTH = 8
) ();

   logic                     send;
   logic [7:0]               send_data;
   logic                     full;
   logic [$clog2(DEPTH):0]   count;

   modport master (output send, output send_data, input full, input count);
   modport slave  (input send, input send_data, output full, output count);

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous circular-buffer FIFO with occupancy counter
// Ports: clk, rst_n (async active-low), push/push_data, pop/pop_data,
//        full/empty (registered, from next-state count), count.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_next;
   logic             do_push;
   logic             do_pop;

   // A push against a full FIFO is refused even if a pop happens the same
   // cycle; full only drops on the following cycle.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + CW'(1);
      end else if (!do_push && do_pop) begin
         count_next = count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/spart_tx_buffer.sv
// rtl/spart_tx_buffer.sv - SPART transmit FIFO and 8N1 serializer
// Ports: clk, rst_n (async active-low), host (send port slave: send, send_data,
//        full, count), txd (serial line, idles high), tx_busy (frame or queue).
module spart_tx_buffer
   import spart_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter logic [15:0] BAUD_DIV = DEFAULT_BAUD_DIV
) (
   input  logic               clk,
   input  logic               rst_n,
   spart_tx_buffer_if.slave   host,
   output logic               txd,
   output logic               tx_busy
);

   localparam int CW = $clog2(DEPTH) + 1;

   tx_state_t     state, state_next;
   logic [15:0]   baud_cnt, baud_next;
   logic [2:0]    bit_idx, idx_next;
   logic [7:0]    shift, shift_next;
   logic          txd_next;
   logic          pop;
   logic          baud_tick;
   logic [7:0]    fifo_data;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (host.send),
      .push_data (host.send_data),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign host.full  = fifo_full;
   assign host.count = fifo_count;
   assign tx_busy    = (state != IDLE) | (fifo_count != '0);
   assign baud_tick  = (baud_cnt == BAUD_DIV - 16'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         txd      <= 1'b1;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         bit_idx  <= idx_next;
         shift    <= shift_next;
         txd      <= txd_next;
      end
   end

   // txd is registered: the value computed here is the line level for the
   // bit period that starts after this edge.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      idx_next   = bit_idx;
      shift_next = shift;
      txd_next   = txd;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            txd_next = 1'b1;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = fifo_data;
               baud_next  = '0;
               txd_next   = 1'b0;
               state_next = START;
            end
         end
         START: begin
            if (baud_tick) begin
               baud_next  = '0;
               idx_next   = '0;
               txd_next   = shift[0];
               state_next = DATA;
            end else begin
               baud_next = baud_cnt + 16'd1;
            end
         end
         DATA: begin
            if (baud_tick) begin
               baud_next = '0;
               if (bit_idx == 3'(DATA_BITS - 1)) begin
                  txd_next   = 1'b1;
                  state_next = STOP;
               end else begin
                  // Next bit is shift[1], which becomes shift[0] after the shift.
                  shift_next = shift >> 1;
                  idx_next   = bit_idx + 3'd1;
                  txd_next   = shift[1];
               end
            end else begin
               baud_next = baud_cnt + 16'd1;
            end
         end
         STOP: begin
            if (baud_tick) begin
               baud_next = '0;
               // Chain straight into the next start bit when more is queued.
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  shift_next = fifo_data;
                  txd_next   = 1'b0;
                  state_next = START;
               end else begin
                  txd_next   = 1'b1;
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_cnt + 16'd1;
            end
         end
         default: begin
            state_next = IDLE;
            txd_next   = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_spart_tx_buffer.sv
// tb/tb_spart_tx_buffer.sv - scoreboard bench for spart_tx_buffer
module tb_spart_tx_buffer;

   localparam int          DEPTH = 4;
   localparam logic [15:0] BAUD  = 16'd4;
   localparam int          B     = 4;
   localparam int          FLEN  = 10 * B;

   typedef struct {
      logic [7:0] data;
      int         start;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic txd;
   logic tx_busy;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_miss = 0;
   exp_t exp_q[$];

   spart_tx_buffer_if #(.DEPTH(DEPTH)) bus ();

   spart_tx_buffer #(.DEPTH(DEPTH), .BAUD_DIV(BAUD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .host    (bus.slave),
      .txd     (txd),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_frame(input logic [7:0] d, input int s);
      exp_t e;
      e.data  = d;
      e.start = s;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic s, input logic [7:0] d);
      bus.send      = s;
      bus.send_data = d;
   endtask

   task automatic to_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Line monitor: decodes each frame from negedge samples and scores it
   // against the head of the expected queue.
   initial begin : monitor
      exp_t       e;
      logic [9:0] frame;
      logic [9:0] got;
      int         start;
      int         bad;
      bit         aborted;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && txd === 1'b0) begin
            start   = cyc;
            bad     = 0;
            aborted = 0;
            got     = '0;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_frame: start bit at cycle %0d, expected none", start);
               frame = 10'h3FE;
            end else begin
               e     = exp_q[0];
               frame = {1'b1, e.data, 1'b0};
            end
            for (int j = 0; j < FLEN; j++) begin
               if (j > 0) @(negedge clk);
               if (rst_n !== 1'b1) begin
                  aborted = 1;
                  break;
               end
               if (txd !== frame[j / B]) bad++;
               if (j % B == 1) got[j / B] = txd;
            end
            if (!aborted && exp_q.size() != 0) begin
               check($sformatf("frame_bits_%02h", e.data), {22'd0, got}, {22'd0, frame});
               check($sformatf("frame_stable_%02h", e.data), bad, 0);
               check($sformatf("frame_start_%02h", e.data), start, e.start);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin : stim
      int m;
      int t;
      drive(1'b0, 8'h00);
      rst_n = 1'b0;

      // Reset held while send toggles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive((i % 2) == 0, 8'h5A);
         #1;
         check("rst_txd", txd, 1);
         check("rst_count", bus.count, 0);
         check("rst_full", bus.full, 0);
         check("rst_busy", tx_busy, 0);
      end
      @(negedge clk);
      drive(1'b0, 8'h00);
      rst_n = 1'b1;

      // Single byte.
      @(negedge clk);
      m = cyc;
      drive(1'b1, 8'hA5);
      expect_frame(8'hA5, m + 2);
      to_cyc(m + 1);
      drive(1'b0, 8'h00);
      check("single_count_after_push", bus.count, 1);
      to_cyc(m + 2);
      check("single_count_after_pop", bus.count, 0);
      check("single_busy_mid", tx_busy, 1);
      to_cyc(m + 41);
      check("single_busy_stop", tx_busy, 1);
      to_cyc(m + 42);
      check("single_busy_end", tx_busy, 0);
      check("single_txd_idle", txd, 1);
      to_cyc(m + 45);

      // Fill and refuse: 01..05 accepted, 06 dropped while full.
      m = cyc;
      for (int k = 0; k < 6; k++) begin
         to_cyc(m + k);
         if (k == 5) begin
            check("fill_full_set", bus.full, 1);
            check("fill_count4", bus.count, 4);
         end
         drive(1'b1, 8'(k + 1));
         if (k < 5) expect_frame(8'(k + 1), m + 2 + FLEN * k);
      end
      to_cyc(m + 6);
      drive(1'b0, 8'h00);
      check("fill_refused_count", bus.count, 4);
      check("fill_refused_full", bus.full, 1);
      to_cyc(m + 202);
      check("fill_idle_after", tx_busy, 0);
      to_cyc(m + 205);

      // Full collision: send on the pop edge while full is refused.
      m = cyc;
      for (int k = 0; k < 5; k++) begin
         to_cyc(m + k);
         drive(1'b1, 8'h10 + 8'(k));
         expect_frame(8'h10 + 8'(k), m + 2 + FLEN * k);
      end
      to_cyc(m + 5);
      drive(1'b0, 8'h00);
      to_cyc(m + 41);
      check("fcol_full_before", bus.full, 1);
      check("fcol_count_before", bus.count, 4);
      drive(1'b1, 8'h15);
      to_cyc(m + 42);
      check("fcol_full_dropped", bus.full, 0);
      check("fcol_count_after_pop", bus.count, 3);
      drive(1'b1, 8'h15);
      expect_frame(8'h15, m + 2 + FLEN * 5);
      to_cyc(m + 43);
      drive(1'b0, 8'h00);
      check("fcol_count_reaccepted", bus.count, 4);
      check("fcol_full_again", bus.full, 1);
      to_cyc(m + 245);

      // Push/pop collision at count 3, pointers wrapping.
      m = cyc;
      for (int k = 0; k < 4; k++) begin
         to_cyc(m + k);
         drive(1'b1, 8'h20 + 8'(k));
         expect_frame(8'h20 + 8'(k), m + 2 + FLEN * k);
      end
      to_cyc(m + 4);
      drive(1'b0, 8'h00);
      check("pcol_count3", bus.count, 3);
      to_cyc(m + 41);
      check("pcol_count3_before", bus.count, 3);
      drive(1'b1, 8'h24);
      expect_frame(8'h24, m + 2 + FLEN * 4);
      to_cyc(m + 42);
      drive(1'b0, 8'h00);
      check("pcol_count3_after", bus.count, 3);
      check("pcol_not_full", bus.full, 0);
      to_cyc(m + 205);

      // Mid-frame reset during data bit 3 of 8'h00 (line low there).
      m = cyc;
      drive(1'b1, 8'h00);
      expect_frame(8'h00, m + 2);
      to_cyc(m + 1);
      drive(1'b1, 8'h77);
      to_cyc(m + 2);
      drive(1'b0, 8'h00);
      to_cyc(m + 19);
      check("mrst_txd_low_before", txd, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_txd_high", txd, 1);
      check("mrst_busy", tx_busy, 0);
      check("mrst_count", bus.count, 0);
      exp_q.delete();
      to_cyc(m + 22);
      rst_n = 1'b1;
      to_cyc(m + 24);
      check("mrst_idle_txd", txd, 1);
      m = cyc;
      drive(1'b1, 8'h3C);
      expect_frame(8'h3C, m + 2);
      to_cyc(m + 1);
      drive(1'b0, 8'h00);
      to_cyc(m + 45);
      check("mrst_busy_end", tx_busy, 0);

      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
